// File: rtl/sobel_pixel_feeder.sv
// -----------------------------------------------------------------------------
// sobel_pixel_feeder
//
// Reads one raster-order 8-bit frame out of a synchronous frame RAM and feeds
// it into the Sobel core's pixel input. It issues the core's Start pulse,
// presents pixels under a valid/ready handshake and then waits for the core's
// Finish before reporting Done.
//
// Ports:
//   CLK            system clock, rising edge
//   Reset_n        asynchronous active-low reset
//   Go             frame request, honoured only while idle
//   Mem_Rd         RAM read strobe
//   Mem_Addr       RAM read address (BASE_ADDR + pixel index)
//   Mem_Data       RAM read data, valid the cycle after Mem_Rd
//   Sobel_Start    one-cycle start pulse to the core
//   Sobel_DataIn   pixel presented to the core (buffer head)
//   Sobel_Valid    Sobel_DataIn holds a valid pixel
//   Sobel_isReady  core accepts a pixel this cycle
//   Sobel_Finish   core has finished the frame
//   Busy           high whenever not idle
//   Done           one-cycle pulse at frame end
//   Error          sticky: Finish arrived before the whole frame was sent
//   Pix_Row        row of the next pixel to be sent
//   Pix_Col        column of the next pixel to be sent
// -----------------------------------------------------------------------------
module sobel_pixel_feeder #(
  parameter int          IMG_W     = 8,
  parameter int          IMG_H     = 8,
  parameter int          ADDR_W    = 16,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Go,
  output logic              Mem_Rd,
  output logic [ADDR_W-1:0] Mem_Addr,
  input  logic [7:0]        Mem_Data,
  output logic              Sobel_Start,
  output logic [7:0]        Sobel_DataIn,
  output logic              Sobel_Valid,
  input  logic              Sobel_isReady,
  input  logic              Sobel_Finish,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [7:0]        Pix_Row,
  output logic [7:0]        Pix_Col
);

  localparam int                NPIX     = IMG_W * IMG_H;
  localparam int                CNT_W    = ADDR_W + 1;
  localparam logic [CNT_W-1:0]  NPIX_C   = CNT_W'(NPIX);
  localparam logic [CNT_W-1:0]  LAST_C   = CNT_W'(NPIX - 1);
  localparam logic [7:0]        COL_LAST = 8'(IMG_W - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CNT_W-1:0] rd_idx_q;
  logic [CNT_W-1:0] send_idx_q;
  logic             rd_vld_p1;
  logic [7:0]       buf_head_p2;
  logic [7:0]       buf_tail_p2;
  logic [1:0]       buf_occ_p2;
  logic             err_q;
  logic [7:0]       row_q;
  logic [7:0]       col_q;

  logic             xfer;
  logic             last_xfer;
  logic             streaming;
  logic             flush;
  logic             push;
  logic [2:0]       slots_used;
  logic             rd_issue;

  assign streaming = (state_q == S_STREAM);
  assign xfer      = Sobel_Valid & Sobel_isReady;
  assign last_xfer = xfer && (send_idx_q == LAST_C);
  assign flush     = streaming && Sobel_Finish;
  assign push      = streaming && rd_vld_p1 && !flush;

  // A pixel popped this cycle frees its slot, so the engine can keep one read
  // in flight per cycle with only two buffer entries.
  assign slots_used = 3'(buf_occ_p2) + 3'(rd_vld_p1) - 3'(xfer);
  assign rd_issue   = streaming && !Sobel_Finish && (rd_idx_q < NPIX_C) &&
                      (slots_used < 3'd2);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (Go) state_d = S_START;
      S_START:  state_d = S_STREAM;
      S_STREAM: begin
        if (Sobel_Finish)   state_d = S_DONE;
        else if (last_xfer) state_d = S_DRAIN;
      end
      S_DRAIN:  if (Sobel_Finish) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= S_IDLE;
      rd_idx_q   <= '0;
      send_idx_q <= '0;
      err_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
    end else begin
      state_q <= state_d;

      if (state_q == S_START)  rd_idx_q <= '0;
      else if (rd_issue)       rd_idx_q <= rd_idx_q + 1'b1;

      if (state_q == S_START)  err_q <= 1'b0;
      else if (flush)          err_q <= 1'b1;

      if (state_q == S_START) begin
        send_idx_q <= '0;
        row_q      <= '0;
        col_q      <= '0;
      end else if (last_xfer) begin
        send_idx_q <= '0;
        row_q      <= '0;
        col_q      <= '0;
      end else if (xfer) begin
        send_idx_q <= send_idx_q + 1'b1;
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= row_q + 8'd1;
        end else begin
          col_q <= col_q + 8'd1;
        end
      end
    end
  end

  // p0 -> p1: read issued, RAM data appears on Mem_Data next cycle
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) rd_vld_p1 <= 1'b0;
    else          rd_vld_p1 <= rd_issue;
  end

  // p1 -> p2: returned data lands in the two-entry buffer, head drives the core
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      buf_head_p2 <= '0;
      buf_tail_p2 <= '0;
      buf_occ_p2  <= '0;
    end else if (flush) begin
      buf_occ_p2 <= '0;
    end else if (push && xfer) begin
      if (buf_occ_p2 == 2'd1) begin
        buf_head_p2 <= Mem_Data;
      end else begin
        buf_head_p2 <= buf_tail_p2;
        buf_tail_p2 <= Mem_Data;
      end
    end else if (push) begin
      if (buf_occ_p2 == 2'd0) buf_head_p2 <= Mem_Data;
      else                    buf_tail_p2 <= Mem_Data;
      buf_occ_p2 <= buf_occ_p2 + 2'd1;
    end else if (xfer) begin
      buf_head_p2 <= buf_tail_p2;
      buf_occ_p2  <= buf_occ_p2 - 2'd1;
    end
  end

  assign Mem_Rd       = rd_issue;
  assign Mem_Addr     = BASE + rd_idx_q[ADDR_W-1:0];
  assign Sobel_Start  = (state_q == S_START);
  assign Sobel_DataIn = buf_head_p2;
  assign Sobel_Valid  = (buf_occ_p2 != 2'd0);
  assign Busy         = (state_q != S_IDLE);
  assign Done         = (state_q == S_DONE);
  assign Error        = err_q;
  assign Pix_Row      = row_q;
  assign Pix_Col      = col_q;

endmodule

// File: tb/tb_sobel_pixel_feeder.sv
// -----------------------------------------------------------------------------
// tb_sobel_pixel_feeder
//
// Directed bench for sobel_pixel_feeder on a 4x4 frame at BASE_ADDR 0x100.
// The frame RAM returns the low address byte, so pixel i reads back as i.
// A negedge monitor records reads, transfers and stall behaviour; the main
// initial block drives stimulus just after each rising edge and checks.
// -----------------------------------------------------------------------------
module tb_sobel_pixel_feeder;

  logic        CLK = 1'b0;
  logic        Reset_n;
  logic        Go;
  logic        Mem_Rd;
  logic [15:0] Mem_Addr;
  logic [7:0]  Mem_Data;
  logic        Sobel_Start;
  logic [7:0]  Sobel_DataIn;
  logic        Sobel_Valid;
  logic        Sobel_isReady;
  logic        Sobel_Finish;
  logic        Busy;
  logic        Done;
  logic        Error;
  logic [7:0]  Pix_Row;
  logic [7:0]  Pix_Col;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 CLK = ~CLK;

  sobel_pixel_feeder #(
    .IMG_W(4), .IMG_H(4), .ADDR_W(16), .BASE_ADDR(32'h100)
  ) dut (
    .CLK(CLK), .Reset_n(Reset_n), .Go(Go),
    .Mem_Rd(Mem_Rd), .Mem_Addr(Mem_Addr), .Mem_Data(Mem_Data),
    .Sobel_Start(Sobel_Start), .Sobel_DataIn(Sobel_DataIn),
    .Sobel_Valid(Sobel_Valid), .Sobel_isReady(Sobel_isReady),
    .Sobel_Finish(Sobel_Finish), .Busy(Busy), .Done(Done), .Error(Error),
    .Pix_Row(Pix_Row), .Pix_Col(Pix_Col)
  );

  // Synchronous frame RAM: RAM[0x100+i] = i
  always @(posedge CLK) if (Mem_Rd) Mem_Data <= Mem_Addr[7:0];

  // Monitor
  logic       mon_clr;
  logic [7:0] got[$];
  int rd_cnt, addr_bad, stall_bad, max_out, start_cnt, done_cnt;
  int xf_first, xf_last, cyc_n;
  logic       hold;
  logic [7:0] hold_d;

  initial cyc_n = 0;

  always @(negedge CLK) begin
    int outst;
    cyc_n = cyc_n + 1;
    if (mon_clr) begin
      got.delete();
      rd_cnt = 0; addr_bad = 0; stall_bad = 0; max_out = 0;
      start_cnt = 0; done_cnt = 0; xf_first = -1; xf_last = -1;
      hold = 1'b0; hold_d = '0;
    end else if (Reset_n) begin
      outst = rd_cnt - got.size();
      if (outst > max_out) max_out = outst;
      if (Mem_Rd) begin
        if (Mem_Addr !== (16'h100 + rd_cnt[15:0])) addr_bad = addr_bad + 1;
        rd_cnt = rd_cnt + 1;
      end
      if (hold && Sobel_Valid && (Sobel_DataIn !== hold_d)) stall_bad = stall_bad + 1;
      hold   = Sobel_Valid && !Sobel_isReady;
      hold_d = Sobel_DataIn;
      if (Sobel_Valid && Sobel_isReady) begin
        got.push_back(Sobel_DataIn);
        if (xf_first < 0) xf_first = cyc_n;
        xf_last = cyc_n;
      end
      if (Sobel_Start) start_cnt = start_cnt + 1;
      if (Done)        done_cnt  = done_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt = vec_cnt + 1;
    assert (obs === exp) else begin
      err_cnt = err_cnt + 1;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    cyc();
    mon_clr = 1'b0;
  endtask

  task automatic wait_got(input string tag, input int n, input int bound);
    for (int k = 0; k < bound && got.size() < n; k++) cyc();
    chk(tag, got.size(), n);
  endtask

  task automatic chk_seq(input string tag, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n && i < got.size(); i++)
      if (got[i] !== 8'(i)) bad = bad + 1;
    chk({tag, "_len"}, got.size(), n);
    chk({tag, "_order"}, bad, 0);
  endtask

  task automatic finish_frame(input string tag, input logic exp_err);
    Sobel_Finish = 1'b1;
    cyc();
    chk({tag, "_done_pulse"}, Done, 1'b1);
    chk({tag, "_error"}, Error, exp_err);
    Sobel_Finish = 1'b0;
    cyc();
    chk({tag, "_done_clear"}, Done, 1'b0);
    chk({tag, "_idle"}, Busy, 1'b0);
  endtask

  task automatic start_frame();
    Go = 1'b1;
    cyc();
    Go = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n = 1'b0; Go = 1'b0; Sobel_isReady = 1'b1; Sobel_Finish = 1'b0;
    mon_clr = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy",   Busy, 1'b0);
    chk("rst_done",   Done, 1'b0);
    chk("rst_error",  Error, 1'b0);
    chk("rst_rd",     Mem_Rd, 1'b0);
    chk("rst_addr",   Mem_Addr, 16'h100);
    chk("rst_valid",  Sobel_Valid, 1'b0);
    chk("rst_data",   Sobel_DataIn, 8'h00);
    chk("rst_start",  Sobel_Start, 1'b0);
    chk("rst_pos",    {Pix_Row, Pix_Col}, 16'h0000);
    Reset_n = 1'b1;
    cyc();
    cyc();
    mon_clr = 1'b0;

    // Full frame, isReady held high
    Go = 1'b1;
    cyc();
    chk("t1_start", Sobel_Start, 1'b1);
    chk("t1_busy",  Busy, 1'b1);
    Go = 1'b0;
    cyc();
    chk("t1_start_off", Sobel_Start, 1'b0);
    chk("t1_rd0",       Mem_Rd, 1'b1);
    chk("t1_addr0",     Mem_Addr, 16'h100);
    cyc();
    chk("t1_valid_c2", Sobel_Valid, 1'b0);
    cyc();
    chk("t1_valid_c3", Sobel_Valid, 1'b1);
    chk("t1_data0",    Sobel_DataIn, 8'h00);
    wait_got("t1_wait", 16, 100);
    chk_seq("t1_seq", 16);
    chk("t1_reads",     rd_cnt, 16);
    chk("t1_addr_seq",  addr_bad, 0);
    chk("t1_b2b",       xf_last - xf_first, 15);
    chk("t1_pos_end",   {Pix_Row, Pix_Col}, 16'h0000);
    chk("t1_drain_busy", Busy, 1'b1);
    chk("t1_drain_rd",   Mem_Rd, 1'b0);
    repeat (4) cyc();
    chk("t1_no_done", Done, 1'b0);
    finish_frame("t1", 1'b0);

    // isReady toggling 1,0,0,1
    clr_mon();
    start_frame();
    for (int k = 0; k < 200 && got.size() < 16; k++) begin
      Sobel_isReady = ((k % 4) == 0) || ((k % 4) == 3);
      cyc();
    end
    Sobel_isReady = 1'b1;
    chk_seq("t2_seq", 16);
    chk("t2_reads",  rd_cnt, 16);
    chk("t2_addr",   addr_bad, 0);
    chk("t2_stable", stall_bad, 0);
    chk("t2_outst",  max_out <= 2, 1'b1);
    finish_frame("t2", 1'b0);

    // isReady low for 10 cycles from START
    clr_mon();
    Sobel_isReady = 1'b0;
    start_frame();
    repeat (10) cyc();
    chk("t3_reads", rd_cnt, 2);
    chk("t3_valid", Sobel_Valid, 1'b1);
    chk("t3_data",  Sobel_DataIn, 8'h00);
    chk("t3_stable", stall_bad, 0);
    Sobel_isReady = 1'b1;
    wait_got("t3_wait", 16, 100);
    chk_seq("t3_seq", 16);
    chk("t3_reads_all", rd_cnt, 16);
    finish_frame("t3", 1'b0);

    // Early Finish after 7 transfers
    clr_mon();
    start_frame();
    wait_got("t4_wait", 7, 100);
    Sobel_isReady = 1'b0;
    Sobel_Finish  = 1'b1;
    cyc();
    chk("t4_done",  Done, 1'b1);
    chk("t4_error", Error, 1'b1);
    chk("t4_flush", Sobel_Valid, 1'b0);
    Sobel_Finish  = 1'b0;
    Sobel_isReady = 1'b1;
    cyc();
    chk("t4_idle",       Busy, 1'b0);
    chk("t4_err_sticky", Error, 1'b1);
    chk("t4_no_rd",      Mem_Rd, 1'b0);
    clr_mon();
    Go = 1'b1;
    cyc();
    Go = 1'b0;
    chk("t4_start_err", Error, 1'b1);
    cyc();
    chk("t4_err_clr", Error, 1'b0);
    wait_got("t4_wait2", 16, 100);
    chk_seq("t4_seq", 16);
    finish_frame("t4", 1'b0);

    // Reset at transfer 9
    clr_mon();
    start_frame();
    wait_got("t5_wait", 9, 100);
    Reset_n = 1'b0;
    #1;
    chk("t5_busy",  Busy, 1'b0);
    chk("t5_valid", Sobel_Valid, 1'b0);
    chk("t5_data",  Sobel_DataIn, 8'h00);
    chk("t5_rd",    Mem_Rd, 1'b0);
    chk("t5_addr",  Mem_Addr, 16'h100);
    chk("t5_pos",   {Pix_Row, Pix_Col}, 16'h0000);
    cyc();
    Reset_n = 1'b1;
    cyc();
    chk("t5_no_done", done_cnt, 0);
    clr_mon();
    start_frame();
    chk("t5_pos_restart", {Pix_Row, Pix_Col}, 16'h0000);
    wait_got("t5_wait2", 16, 100);
    chk_seq("t5_seq", 16);
    finish_frame("t5", 1'b0);

    // Go ignored while busy, column wrap
    clr_mon();
    start_frame();
    wait_got("t6_wait", 3, 100);
    chk("t6_pos_03", {Pix_Row, Pix_Col}, 16'h0003);
    Go = 1'b1;
    cyc();
    chk("t6_pos_10", {Pix_Row, Pix_Col}, 16'h0100);
    Go = 1'b0;
    wait_got("t6_wait2", 16, 100);
    Go = 1'b1;
    cyc();
    cyc();
    Go = 1'b0;
    chk("t6_drain_busy", Busy, 1'b1);
    chk("t6_starts",     start_cnt, 1);
    finish_frame("t6", 1'b0);
    cyc();
    chk("t6_stay_idle", Busy, 1'b0);
    chk("t6_reads",     rd_cnt, 16);
    chk_seq("t6_seq", 16);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
